// File: rtl/mem_arbiter.sv
// Two-master memory arbiter. Grants one access at a time with round-robin
// fairness. It drives the memory strobes, waits for mem_ready, and returns a
// one-cycle done (and err on watchdog abort) pulse to the owning master.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner
);

  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last_owner, last_owner_nxt;
  logic              owner_nxt;
  logic              win;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              mem_rd_nxt, mem_wr_nxt;
  logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic              m0_done_nxt, m1_done_nxt, m0_err_nxt, m1_err_nxt;
  logic              busy_nxt;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_owner_nxt = last_owner;
    owner_nxt      = owner;
    win            = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_rd_nxt     = mem_rd;
    mem_wr_nxt     = mem_wr;
    m0_rdata_nxt   = m0_rdata;
    m1_rdata_nxt   = m1_rdata;
    m0_done_nxt    = 1'b0;
    m1_done_nxt    = 1'b0;
    m0_err_nxt     = 1'b0;
    m1_err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that did not go last wins.
          win            = (m0_req && m1_req) ? ~last_owner : m1_req;
          owner_nxt      = win;
          last_owner_nxt = win;
          cnt_nxt        = '0;
          mem_addr_nxt   = win ? m1_addr  : m0_addr;
          mem_wdata_nxt  = win ? m1_wdata : m0_wdata;
          mem_wr_nxt     = win ? m1_wr    : m0_wr;
          mem_rd_nxt     = ~(win ? m1_wr  : m0_wr);
          state_nxt      = BUSY;
        end
      end
      BUSY: begin
        // Ready takes priority over a watchdog expiry on the same edge.
        if (mem_ready) begin
          if (mem_rd) begin
            if (owner) m1_rdata_nxt = mem_rdata;
            else       m0_rdata_nxt = mem_rdata;
          end
          mem_rd_nxt  = 1'b0;
          mem_wr_nxt  = 1'b0;
          m0_done_nxt = ~owner;
          m1_done_nxt = owner;
          state_nxt   = RESP;
        end else if (TIMEOUT != 0) begin
          if (cnt == CNT_LAST) begin
            mem_rd_nxt  = 1'b0;
            mem_wr_nxt  = 1'b0;
            m0_done_nxt = ~owner;
            m1_done_nxt = owner;
            m0_err_nxt  = ~owner;
            m1_err_nxt  = owner;
            state_nxt   = RESP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        mem_rd_nxt = 1'b0;
        mem_wr_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_owner <= last_owner_nxt;
      owner      <= owner_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_rd     <= mem_rd_nxt;
      mem_wr     <= mem_wr_nxt;
      m0_rdata   <= m0_rdata_nxt;
      m1_rdata   <= m1_rdata_nxt;
      m0_done    <= m0_done_nxt;
      m1_done    <= m1_done_nxt;
      m0_err     <= m0_err_nxt;
      m1_err     <= m1_err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and randomized accesses checked against a
// transaction-level model (pending requests, round-robin choice, latency
// versus watchdog limit, per-master read-data history).
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic          m0_done, m0_err, m1_done, m1_err;
  logic          mem_rd, mem_wr, mem_ready, busy, owner;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            pend [2];
  bit            pwr  [2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pwd  [2];
  logic [DW-1:0] exp_rd[2];
  int            last_own;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_reqs();
    m0_req = pend[0]; m0_wr = pwr[0]; m0_addr = paddr[0]; m0_wdata = pwd[0];
    m1_req = pend[1]; m1_wr = pwr[1]; m1_addr = paddr[1]; m1_wdata = pwd[1];
  endtask

  task automatic new_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1; pwr[i] = wr; paddr[i] = a; pwd[i] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},    32'(mem_rd), 0);
    chk({tag, "_wr"},    32'(mem_wr), 0);
    chk({tag, "_addr"},  32'(mem_addr), 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_done"},  {30'd0, m1_done, m0_done}, 0);
    chk({tag, "_err"},   {30'd0, m1_err, m0_err}, 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_owner"}, 32'(owner), 0);
    chk({tag, "_rdata0"}, m0_rdata, 0);
    chk({tag, "_rdata1"}, m1_rdata, 0);
  endtask

  // One full access from IDLE; lat = cycle in BUSY on which ready rises
  // (values above TMO mean the memory never answers in time).
  task automatic do_access(input int lat, input bit force_data, input logic [DW-1:0] fdata);
    int w;
    int done_at;
    bit err;
    logic [DW-1:0] rv;
    rv = '0;
    if (pend[0] && pend[1]) w = (last_own == 0) ? 1 : 0;
    else                    w = pend[0] ? 0 : 1;
    drive_reqs();
    mem_ready = 1'b0;
    step();
    chk("grant_owner", 32'(owner), 32'(w));
    chk("grant_busy",  32'(busy), 1);
    chk("grant_rd",    32'(mem_rd), 32'(!pwr[w]));
    chk("grant_wr",    32'(mem_wr), 32'(pwr[w]));
    chk("grant_addr",  32'(mem_addr), 32'(paddr[w]));
    chk("grant_wdata", mem_wdata, pwd[w]);
    chk("grant_done",  {30'd0, m1_done, m0_done}, 0);
    last_own = w;
    done_at = (lat <= TMO) ? lat : TMO;
    err = (lat > TMO);
    for (int k = 1; k <= done_at; k++) begin
      mem_ready = (k == lat);
      mem_rdata = force_data ? fdata : $urandom;
      if (k == lat) rv = mem_rdata;
      step();
      mem_ready = 1'b0;
      if (k < done_at) begin
        chk("hold_rd",   32'(mem_rd), 32'(!pwr[w]));
        chk("hold_wr",   32'(mem_wr), 32'(pwr[w]));
        chk("hold_addr", 32'(mem_addr), 32'(paddr[w]));
        chk("hold_done", {30'd0, m1_done, m0_done}, 0);
      end else begin
        if (!pwr[w] && !err) exp_rd[w] = rv;
        chk("resp_done",  {30'd0, m1_done, m0_done}, (w == 1) ? 32'd2 : 32'd1);
        chk("resp_err",   {30'd0, m1_err, m0_err}, err ? ((w == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk("resp_strb",  {30'd0, mem_wr, mem_rd}, 0);
        chk("resp_busy",  32'(busy), 1);
        chk("resp_owner", 32'(owner), 32'(w));
        chk("rdata0",     m0_rdata, exp_rd[0]);
        chk("rdata1",     m1_rdata, exp_rd[1]);
      end
    end
    // Owner drops req during its done cycle.
    pend[w] = 1'b0;
    drive_reqs();
    step();
    chk("idle_done",  {30'd0, m1_done, m0_done}, 0);
    chk("idle_err",   {30'd0, m1_err, m0_err}, 0);
    chk("idle_busy",  32'(busy), 0);
    chk("idle_owner", 32'(owner), 32'(w));
  endtask

  task automatic drain();
    while (pend[0] || pend[1]) do_access(1, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    pend[0] = 0; pend[1] = 0; pwr[0] = 0; pwr[1] = 0;
    paddr[0] = '0; paddr[1] = '0; pwd[0] = '0; pwd[1] = '0;
    exp_rd[0] = '0; exp_rd[1] = '0; last_own = 1;
    drive_reqs();
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single read by m0, ready on 2nd BUSY cycle
    new_req(0, 1'b0, 16'h0010, '0);
    do_access(2, 1'b1, 32'hDEADBEEF);
    chk("read_value", m0_rdata, 32'hDEADBEEF);

    // Single write by m1, ready immediately
    new_req(1, 1'b1, 16'h00FF, 32'h12345678);
    do_access(1, 1'b0, '0);
    chk("write_rdata1", m1_rdata, 32'h0);

    // Fairness: both keep requesting; owner re-requests in IDLE
    new_req(0, 1'b0, 16'h0100, '0);
    new_req(1, 1'b0, 16'h0200, '0);
    for (int n = 0; n < 4; n++) begin
      do_access(1, 1'b0, '0);
      chk("fair_order", 32'(owner), 32'(n % 2));
      new_req(last_own, 1'b0, 16'(16'h0100 * (last_own + 1) + n), '0);
    end
    drain();

    // Timeout and ready/timeout collision, each followed by a normal access
    new_req(0, 1'b0, 16'h0AAA, '0);
    do_access(TMO + 3, 1'b0, '0);
    new_req(1, 1'b0, 16'h0BBB, '0);
    do_access(1, 1'b0, '0);
    new_req(0, 1'b0, 16'h0CCC, '0);
    do_access(TMO, 1'b1, 32'hCAFEF00D);
    chk("collide_rdata", m0_rdata, 32'hCAFEF00D);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0)
          new_req(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
      if (!pend[0] && !pend[1]) begin
        drive_reqs();
        step();
        chk("idle_stay", 32'(busy), 0);
      end else begin
        do_access($urandom_range(1, TMO + 2), 1'b0, '0);
      end
    end
    drain();

    // Reset in the middle of a read
    new_req(0, 1'b0, 16'h0123, '0);
    drive_reqs();
    mem_ready = 1'b0;
    step();
    chk("mid_rd", 32'(mem_rd), 1);
    step();
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    pend[0] = 0;
    exp_rd[0] = '0; exp_rd[1] = '0; last_own = 1;
    new_req(0, 1'b0, 16'h0321, '0);
    new_req(1, 1'b0, 16'h0456, '0);
    drive_reqs();
    step();
    rst = 1'b0;
    do_access(2, 1'b0, '0);
    chk("post_rst_win", 32'(owner), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
